// File: rtl/sparc_exu_div_resfmt.sv
// Divider result formatter: 64-bit quotient range check and 32-bit
// saturation / extension to the rd value, two-stage valid/ready pipe.
module sparc_exu_div_resfmt (
  input  logic        rclk,
  input  logic        arst_l,
  input  logic        kill,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [63:0] in_q,
  input  logic        in_signed,
  input  logic [1:0]  in_tid,
  input  logic        in_cc,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [63:0] out_res,
  output logic        out_ovfl,
  output logic [1:0]  out_tid,
  output logic        out_cc
);

  typedef struct packed {
    logic [63:0] q;
    logic        sgn;
    logic [1:0]  tid;
    logic        cc;
  } s1_t;

  typedef struct packed {
    logic [31:0] lo;
    logic        neg;
    logic        sgn;
    logic        ovfl;
    logic [1:0]  tid;
    logic        cc;
  } s2_t;

  logic s1_vld;
  logic s2_vld;
  s1_t  s1;
  s2_t  s2;
  logic adv;
  logic ld1;
  logic s1_ovfl;
  logic [31:0] res32;

  assign adv    = ~s2_vld | out_rdy;
  assign in_rdy = ~kill & (~s1_vld | adv);
  assign ld1    = in_vld & in_rdy;

  // Signed fits in 32 bits only when bits 63..31 are all copies of the sign
  always_comb begin
    if (s1.sgn)
      s1_ovfl = ~((&s1.q[63:31]) | ~(|s1.q[63:31]));
    else
      s1_ovfl = |s1.q[63:32];
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else if (kill) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      if (adv)
        s2_vld <= s1_vld;
      if (~s1_vld | adv)
        s1_vld <= ld1;
    end
  end

  always_ff @(posedge rclk) begin
    if (ld1) begin
      s1.q   <= in_q;
      s1.sgn <= in_signed;
      s1.tid <= in_tid;
      s1.cc  <= in_cc;
    end
    if (adv & s1_vld) begin
      s2.lo   <= s1.q[31:0];
      s2.neg  <= s1.q[63];
      s2.sgn  <= s1.sgn;
      s2.ovfl <= s1_ovfl;
      s2.tid  <= s1.tid;
      s2.cc   <= s1.cc;
    end
  end

  always_comb begin
    res32 = s2.lo;
    unique case (1'b1)
      s2.ovfl & s2.sgn &  s2.neg: res32 = 32'h8000_0000;
      s2.ovfl & s2.sgn & ~s2.neg: res32 = 32'h7FFF_FFFF;
      s2.ovfl & ~s2.sgn:          res32 = 32'hFFFF_FFFF;
      ~s2.ovfl:                   res32 = s2.lo;
    endcase
  end

  assign out_vld  = s2_vld;
  assign out_res  = s2.sgn ? {{32{res32[31]}}, res32} : {32'h0, res32};
  assign out_ovfl = s2.ovfl;
  assign out_tid  = s2.tid;
  assign out_cc   = s2.cc;

endmodule
